// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side bundle of the UART receiver: FIFO read handshake, head byte and sticky status flags.
interface uart_rx_ctrl_if;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rdy;
  logic       full;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rdy, full, frame_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rdy, full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with mid-bit sampling, a small receive FIFO with registered head,
// and sticky framing/overrun flags.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           x,
  uart_rx_ctrl_if.slave  bus
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              x_meta, xs;
  logic              stop_good, stop_bad;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr, rptr_nxt;
  logic [FCNT_W-1:0] count, count_nxt;
  logic [7:0]        rd_data_q, head_nxt;
  logic              fifo_rdy, fifo_full;
  logic              push, pop, ovr_set;
  logic              frame_err_q, overrun_q;

  // The line is asynchronous; reset to idle-high so no false start appears out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_meta <= 1'b1;
      xs     <= 1'b1;
    end else begin
      x_meta <= x;
      xs     <= x_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // START waits half a bit so that every later full-bit wait lands mid-bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!xs) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = xs ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = xs;
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          stop_good = xs;
          stop_bad  = !xs;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rdy  = (count != '0);
  assign fifo_full = (count == DEPTH_C);
  assign pop       = bus.rd_en && fifo_rdy;
  assign push      = stop_good && (!fifo_full || pop);
  assign ovr_set   = stop_good && fifo_full && !pop;
  assign rptr_nxt  = pop ? rptr + PTR_W'(1) : rptr;

  // Look ahead to the head after this cycle's push/pop so rd_data can stay a plain register.
  always_comb begin
    head_nxt  = mem[rptr_nxt];
    count_nxt = count;
    if (push && (wptr == rptr_nxt)) head_nxt = shift;
    case ({push, pop})
      2'b10:   count_nxt = count + FCNT_W'(1);
      2'b01:   count_nxt = count - FCNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_data_q <= 8'h00;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      rptr  <= rptr_nxt;
      count <= count_nxt;
      if (count_nxt != '0) rd_data_q <= head_nxt;
    end
  end

  // A set event in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (stop_bad)         frame_err_q <= 1'b1;
      else if (bus.err_clr) frame_err_q <= 1'b0;
      if (ovr_set)          overrun_q   <= 1'b1;
      else if (bus.err_clr) overrun_q   <= 1'b0;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rdy       = fifo_rdy;
  assign bus.full      = fifo_full;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial frames in, a queue of expected bytes is popped
// by a forked monitor whenever a read is accepted; flags and FIFO status are checked inline.
module tb_uart_rx_ctrl;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic x;
  int   checks = 0;
  int   passes = 0;
  bit   done   = 1'b0;
  logic [7:0] sb [$];

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full 8N1 frame; optionally hold rd_en across exactly the stop-sample edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopbit, input bit popAtStop);
    x = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      x = data[i];
      tick(CPB);
    end
    x = stopbit;
    for (int i = 0; i < CPB; i++) begin
      tick(1);
      if (popAtStop && i == 9)  bus.rd_en = 1'b1;
      if (popAtStop && i == 10) bus.rd_en = 1'b0;
    end
    x = 1'b1;
    tick(2);
  endtask

  task automatic readOne();
    checkOutput("rdy_before_read", bus.rdy, 1);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    tick(1);
  endtask

  task automatic clearErr();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
  endtask

  task automatic monitor();
    logic [7:0] exp;
    while (!done) begin
      @(negedge clk);
      if (bus.rd_en === 1'b1 && bus.rdy === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_pop: got %0h, want no byte", bus.rd_data);
        end else begin
          exp = sb.pop_front();
          checkOutput("rd_data", bus.rd_data, exp);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        rst_n       = 1'b0;
        x           = 1'b1;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        tick(3);
        checkOutput("reset_rdy", bus.rdy, 0);
        checkOutput("reset_full", bus.full, 0);
        checkOutput("reset_frame_err", bus.frame_err, 0);
        checkOutput("reset_overrun", bus.overrun, 0);
        checkOutput("reset_rd_data", bus.rd_data, 8'h00);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] single byte A5");
        sb.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkOutput("a5_rdy", bus.rdy, 1);
        checkOutput("a5_frame_err", bus.frame_err, 0);
        readOne();
        checkOutput("a5_rdy_after_pop", bus.rdy, 0);

        $display("[TB] framing error on 3C");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("3c_frame_err", bus.frame_err, 1);
        checkOutput("3c_rdy", bus.rdy, 0);
        clearErr();
        checkOutput("3c_frame_err_cleared", bus.frame_err, 0);
        tick(CPB);

        $display("[TB] start glitch");
        x = 1'b0;
        tick(4);
        x = 1'b1;
        tick(3 * CPB);
        checkOutput("glitch_rdy", bus.rdy, 0);
        checkOutput("glitch_frame_err", bus.frame_err, 0);
        checkOutput("glitch_overrun", bus.overrun, 0);
        sb.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        readOne();

        $display("[TB] overrun with five bytes");
        for (int i = 1; i <= 5; i++) begin
          if (i <= DEPTH) sb.push_back(8'(i));
          applyStimulus(8'(i), 1'b1, 1'b0);
          if (i == 3) checkOutput("ovr_full_after_3", bus.full, 0);
          if (i == 4) begin
            checkOutput("ovr_full_after_4", bus.full, 1);
            checkOutput("ovr_overrun_after_4", bus.overrun, 0);
          end
          if (i == 5) begin
            checkOutput("ovr_overrun_after_5", bus.overrun, 1);
            checkOutput("ovr_full_after_5", bus.full, 1);
          end
        end
        for (int i = 0; i < DEPTH; i++) readOne();
        checkOutput("ovr_drained_rdy", bus.rdy, 0);
        clearErr();
        checkOutput("ovr_cleared", bus.overrun, 0);

        $display("[TB] push and pop in stop-sample cycle while full");
        for (int i = 1; i <= DEPTH; i++) begin
          sb.push_back(8'(i));
          applyStimulus(8'(i), 1'b1, 1'b0);
        end
        checkOutput("sim_full_before", bus.full, 1);
        sb.push_back(8'h77);
        applyStimulus(8'h77, 1'b1, 1'b1);
        checkOutput("sim_overrun", bus.overrun, 0);
        checkOutput("sim_full_after", bus.full, 1);
        checkOutput("sim_frame_err", bus.frame_err, 0);
        for (int i = 0; i < DEPTH; i++) readOne();
        checkOutput("sim_drained_rdy", bus.rdy, 0);

        $display("[TB] reset during FF bit 4");
        x = 1'b0;
        tick(CPB);
        x = 1'b1;
        tick(4 * CPB + CPB / 2);
        rst_n = 1'b0;
        tick(2);
        checkOutput("midreset_rdy", bus.rdy, 0);
        checkOutput("midreset_rd_data", bus.rd_data, 8'h00);
        rst_n = 1'b1;
        tick(2);
        sb.push_back(8'h12);
        applyStimulus(8'h12, 1'b1, 1'b0);
        checkOutput("after_reset_rdy", bus.rdy, 1);
        checkOutput("after_reset_full", bus.full, 0);
        readOne();
        checkOutput("after_reset_only_one", bus.rdy, 0);
        tick(2);
        done = 1'b1;
      end
    join
    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
